pwm_quant_gen: RTL
==================

# pwm_quant_gen

Parametrised successor to the filter-to-PWM truncator. Takes signed two's-complement samples from the digital filter and requantises them to an offset-binary duty word, with saturation flags and optional round-to-nearest. Drives a free-running PWM generator whose duty updates glitch-free at period boundaries. Sits between the filter output and the PWM pin.

## Interface
- IN_W, 25, input sample width (signed)
- OUT_W, 12, duty width; PWM period is 2^OUT_W clocks
- SHIFT, 2, LSBs dropped; window is in_data[SHIFT+OUT_W-1:SHIFT]; requires SHIFT+OUT_W <= IN_W, SHIFT >= 1
- STAT_W, 16, saturation event counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe; one sample per cycle max, no backpressure
- in_data  in  IN_W  signed filter sample
- clr_stat  in  1  synchronous clear of sat_count
- duty  out  OUT_W  latest quantised duty (offset binary)
- duty_valid  out  1  one-cycle strobe with each new duty
- sat_hi  out  1  duty from positive overflow, qualified by duty_valid
- sat_lo  out  1  duty from negative underflow, qualified by duty_valid
- sat_count  out  STAT_W  saturating count of sat_hi|sat_lo events
- pwm_out  out  1  PWM output

## Operation
- Stage 1 (on in_valid): register sample; with rounding, sample + 2^(SHIFT-1) computed at IN_W+1 bits (no wrap).
- Stage 2: bits above window (including window MSB) must all equal sign bit of the IN_W+1 value.
  - Sign 0, mismatch: duty = all ones, sat_hi = 1.
  - Sign 1, mismatch: duty = 0, sat_lo = 1.
  - Else: duty = {~window[OUT_W-1], window[OUT_W-2:0]} (offset binary, signed 0 -> 2^(OUT_W-1)).
- sat_count increments on each saturated sample; sticks at 2^STAT_W-1; clr_stat wins over a same-cycle increment.
- PWM: counter cnt 0..2^OUT_W-1, free-running, wraps to 0.
  - Shadow duty_act loads from duty when cnt == 2^OUT_W-1.
  - pwm_out registered: pwm_out <= (cnt < duty_act).
  - duty 0: pwm_out constantly low; all ones: high 2^OUT_W-1 of 2^OUT_W cycles.
  - Several samples in one period: only the last before wrap takes effect.

## Timing
- Latency in_valid -> duty/duty_valid/sat_*: 2 cycles; full throughput.
- Duty update to pwm_out: effective at the first period starting after the wrap load, plus 1 cycle for the output register.
- Reset values: duty = duty_act = 2^(OUT_W-1), duty_valid = sat_hi = sat_lo = 0, sat_count = 0, cnt = 0, pwm_out = 0, pipeline valids = 0.
- Reset mid-period aborts the period; after release, first period starts at cnt = 0 with midscale duty.
- in_valid low: pipeline holds; duty keeps last value.

## Configuration
- QUANT_ROUND_EN defined: round half up (add 2^(SHIFT-1) before windowing); rounding into overflow saturates and flags sat_hi.
- Undefined: pure truncation (floor); stage-1 adder omitted; latency stays 2.

## Structure
- Package pwm_pkg: default widths, midscale constant function, saturation-kind enum (NONE, HI, LO).
- Sub-module pwm_gen (counter, shadow load, output compare) parametrised by OUT_W; quantiser stays in top.

## Test plan
Defaults (IN_W=25, OUT_W=12, SHIFT=2):
- in 0 -> duty 0x800 two cycles later, no flags; after reset release pwm_out high 2048 of 4096 cycles.
- in 0x0001FFC -> 0xFFF, no flag; in 0x0002000 -> 0xFFF, sat_hi, sat_count 1; clr_stat -> 0.
- in 0x1FFE000 (-8192) -> 0x000, no flag; in 0x1FFDFFF -> 0x000, sat_lo.
- in 0x0000006 -> 0x802 with QUANT_ROUND_EN, 0x801 without; in 0x0001FFE -> 0xFFF plus sat_hi with, 0xFFF no flag without.
- duty 0x004 applied mid-period -> current period unchanged; next period pwm_out high exactly 4 cycles; duty 0 -> constantly low.
- Reset asserted mid-period -> pwm_out, cnt, sat_count 0 immediately; duty back to 0x800.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths, midscale helper and saturation kinds for the requantising PWM block.
package pwm_pkg;
  localparam int DEF_IN_W   = 25;
  localparam int DEF_OUT_W  = 12;
  localparam int DEF_SHIFT  = 2;
  localparam int DEF_STAT_W = 16;

  typedef enum logic [1:0] {SAT_NONE, SAT_HI, SAT_LO} sat_kind_e;

  // Offset-binary code of signed zero for a w-bit duty word.
  function automatic logic [31:0] midscale(input int w);
    return 32'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM: period counter, shadow duty loaded at wrap, registered compare output.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] i_duty,
  output logic             o_pwm
);
  localparam logic [OUT_W-1:0] CNT_MAX = '1;
  localparam logic [OUT_W-1:0] MID     = OUT_W'(midscale(OUT_W));

  logic [OUT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_duty_act;
  logic             r_pwm;

  // Shadow loads on the last count so a new duty starts exactly at cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_duty_act <= MID;
      r_pwm      <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_pwm <= (r_cnt < r_duty_act);
      if (r_cnt == CNT_MAX) r_duty_act <= i_duty;
    end
  end

  assign o_pwm = r_pwm;
endmodule

// File: rtl/pwm_quant_gen.sv
// Filter sample -> offset-binary duty requantiser with saturation flags, driving pwm_gen.
// Define QUANT_ROUND_EN for round-half-up; otherwise the window truncates (floor).
module pwm_quant_gen
  import pwm_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic              clr_stat,
  output logic [OUT_W-1:0]  duty,
  output logic              duty_valid,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic [STAT_W-1:0] sat_count,
  output logic              pwm_out
);
  localparam int               STAGES = 2;
  localparam int               WIN_HI = SHIFT + OUT_W - 1;
  localparam int               HI_W   = IN_W - WIN_HI + 1;
  localparam logic [OUT_W-1:0] MID    = OUT_W'(midscale(OUT_W));

  logic [STAGES:1]   r_vld_pipe;
  logic [IN_W:0]     w_ext;
  logic [IN_W:0]     r_s1;
  logic [HI_W-1:0]   w_hi;
  logic [OUT_W-1:0]  w_win;
  logic              w_sign;
  sat_kind_e         w_kind;
  logic              w_unused_lsb;
  logic [OUT_W-1:0]  r_duty;
  logic              r_sat_hi;
  logic              r_sat_lo;
  logic [STAT_W-1:0] r_sat_count;

  // One extra bit so the rounding add can never wrap.
`ifdef QUANT_ROUND_EN
  localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
  assign w_ext = {in_data[IN_W-1], in_data} + RND;
`else
  assign w_ext = {in_data[IN_W-1], in_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) r_s1 <= w_ext;
    end
  end

  // In range only if everything from the window MSB upward is a copy of the sign.
  assign w_sign       = r_s1[IN_W];
  assign w_hi         = r_s1[IN_W:WIN_HI];
  assign w_win        = r_s1[WIN_HI:SHIFT];
  assign w_unused_lsb = ^r_s1[SHIFT-1:0];

  always_comb begin
    w_kind = SAT_NONE;
    if (w_hi != {HI_W{w_sign}}) w_kind = w_sign ? SAT_LO : SAT_HI;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty   <= MID;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
    end else begin
      r_sat_hi <= r_vld_pipe[1] && (w_kind == SAT_HI);
      r_sat_lo <= r_vld_pipe[1] && (w_kind == SAT_LO);
      if (r_vld_pipe[1]) begin
        unique case (w_kind)
          SAT_HI:  r_duty <= '1;
          SAT_LO:  r_duty <= '0;
          default: r_duty <= {~w_win[OUT_W-1], w_win[OUT_W-2:0]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (clr_stat) begin
      r_sat_count <= '0;
    end else if (r_vld_pipe[1] && (w_kind != SAT_NONE) && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  pwm_gen #(.OUT_W(OUT_W)) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_duty (r_duty),
    .o_pwm  (pwm_out)
  );

  assign duty       = r_duty;
  assign duty_valid = r_vld_pipe[STAGES];
  assign sat_hi     = r_sat_hi;
  assign sat_lo     = r_sat_lo;
  assign sat_count  = r_sat_count;
endmodule
